// File: rtl/polar_pkg.sv
// Shared helpers for the pipelined polar encoder: stage/latency arithmetic
// and parameter legality checks.
`ifndef POLAR_PKG_MACROS
`define POLAR_PKG_MACROS
`define POLAR_IS_POW2(n)     (((n) > 0) && ((((n) & ((n) - 1))) == 0))
`define POLAR_N_IN_RANGE(n)  (((n) >= 4) && ((n) <= 1024))
`endif

package polar_pkg;

    localparam int POLAR_N_MIN = 4;
    localparam int POLAR_N_MAX = 1024;

    function automatic int polar_nstages(input int n);
        return $clog2(n);
    endfunction

    // 1 cycle for the masking register plus one per butterfly group.
    function automatic int polar_latency(input int n, input int spr);
        return 1 + (polar_nstages(n) + spr - 1) / spr;
    endfunction

    function automatic bit polar_n_ok(input int n);
        return `POLAR_IS_POW2(n) && `POLAR_N_IN_RANGE(n);
    endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One Arikan butterfly stage: bits whose index has bit S clear absorb their
// partner 2^S positions above; all other bits pass through.
module polar_butterfly_stage
    import polar_pkg::*;
#(
    parameter int N = 32,
    parameter int S = 0
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    localparam int STRIDE = 1 << S;

    for (genvar b = 0; b < N; b++) begin : g_bit
        if (((b / STRIDE) % 2) == 0) begin : g_xor
            assign dout[b] = din[b] ^ din[b + STRIDE];
        end else begin : g_pass
            assign dout[b] = din[b];
        end
    end

endmodule

// File: rtl/polar_encoder_pipe.sv
// Streaming polar encoder: masks frozen bits, applies all log2(N) butterfly
// stages in groups of SPR per register, with valid/ready on both sides.
module polar_encoder_pipe
    import polar_pkg::*;
#(
    parameter int N     = 32,
    parameter int SPR   = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_data,
    input  logic [N-1:0]     s_frozen,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     m_data,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int NSTAGES  = polar_nstages(N);
    localparam int SPR_SAFE = (SPR < 1) ? 1 : SPR;
    localparam int NG       = polar_latency(N, SPR_SAFE) - 1;

    if (!polar_n_ok(N)) begin : g_bad_n
        $error("polar_encoder_pipe: N=%0d must be a power of two in 4..1024", N);
    end
    if ((SPR < 1) || (SPR > NSTAGES)) begin : g_bad_spr
        $error("polar_encoder_pipe: SPR=%0d must be in 1..%0d", SPR, NSTAGES);
    end

    logic [NG:0] v_q;
    logic [NG:0] adv;
    logic [NG:0] load;
    logic        in_fire;

    // full_above tracks whether every register downstream of k is occupied;
    // if any is empty, k can always move forward (bubbles collapse).
    always_comb begin
        logic full_above;
        full_above = 1'b1;
        adv        = '0;
        for (int k = NG; k >= 0; k--) begin
            adv[k]     = v_q[k] & (m_ready | ~full_above);
            full_above = full_above & v_q[k];
        end
    end

    assign s_ready = ~rst & (~v_q[0] | adv[0]);
    assign in_fire = s_valid & s_ready;
    assign load    = {adv[NG-1:0], in_fire};

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= load | (v_q & ~adv);
        end
    end

    for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
        logic [N-1:0] din;
        logic [N-1:0] dout;
        if ((s % SPR_SAFE) == 0) begin : g_head
            assign din = g_reg[s / SPR_SAFE].q;
        end else begin : g_chain
            assign din = g_stage[s - 1].dout;
        end
        polar_butterfly_stage #(
            .N (N),
            .S (s)
        ) u_bf (
            .din  (din),
            .dout (dout)
        );
    end

    // Register 0 holds the masked frame; register k holds the result of group k.
    for (genvar k = 0; k <= NG; k++) begin : g_reg
        logic [N-1:0] q;
        logic [N-1:0] d;
        if (k == 0) begin : g_in
            assign d = s_data & ~s_frozen;
        end else begin : g_grp
            localparam int LAST_S = (((k * SPR_SAFE) < NSTAGES) ? (k * SPR_SAFE) : NSTAGES) - 1;
            assign d = g_stage[LAST_S].dout;
        end
        if (k == NG) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (load[k]) begin
                    q <= d;
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (load[k]) begin
                    q <= d;
                end
            end
        end
    end

    assign m_valid = v_q[NG];
    assign m_data  = g_reg[NG].q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_valid & m_ready) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_polar_encoder_pipe.sv
// Directed bench for polar_encoder_pipe: N=8/SPR=1, N=32/SPR=2 and a 4-bit
// frame counter instance, each checked against hand values or the generator-matrix form.
module tb_polar_encoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        a_rst, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [7:0]  a_s_data, a_s_frozen, a_m_data;
    logic [31:0] a_frame_cnt;

    logic        b_rst, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_s_frozen, b_m_data;
    logic [31:0] b_frame_cnt;

    logic        c_rst, c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [7:0]  c_s_data, c_s_frozen, c_m_data;
    logic [3:0]  c_frame_cnt;

    polar_encoder_pipe #(.N(8), .SPR(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(a_rst), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .s_data(a_s_data), .s_frozen(a_s_frozen), .m_valid(a_m_valid),
        .m_ready(a_m_ready), .m_data(a_m_data), .frame_cnt(a_frame_cnt)
    );

    polar_encoder_pipe #(.N(32), .SPR(2), .CNT_W(32)) dut_b (
        .clk(clk), .rst(b_rst), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_frozen(b_s_frozen), .m_valid(b_m_valid),
        .m_ready(b_m_ready), .m_data(b_m_data), .frame_cnt(b_frame_cnt)
    );

    polar_encoder_pipe #(.N(8), .SPR(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(c_rst), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .s_data(c_s_data), .s_frozen(c_s_frozen), .m_valid(c_m_valid),
        .m_ready(c_m_ready), .m_data(c_m_data), .frame_cnt(c_frame_cnt)
    );

    localparam logic [7:0] BASIC_IN  [4] = '{8'h80, 8'h02, 8'h01, 8'h10};
    localparam logic [7:0] BASIC_EXP [4] = '{8'hFF, 8'h03, 8'h01, 8'h11};
    localparam logic [7:0] FRZ_IN    [3] = '{8'hFF, 8'hFF, 8'hA5};
    localparam logic [7:0] FRZ_MASK  [3] = '{8'h7F, 8'hFF, 8'h0F};
    localparam logic [7:0] FRZ_EXP   [3] = '{8'hFF, 8'h00, 8'hCC};

    logic [7:0]  bp_din [10];
    logic [7:0]  bp_fz  [10];
    logic [7:0]  bp_exp [10];
    logic [31:0] tp_u   [1000];
    logic [31:0] tp_x   [1000];
    logic [7:0]  wr_u   [17];

    // x[j] = XOR of u[i] over every i whose bit set contains j (rows of F^{(x)n}).
    function automatic logic [31:0] polar_ref(input logic [31:0] u, input int n);
        logic [31:0] x;
        x = '0;
        for (int j = 0; j < n; j++)
            for (int i = 0; i < n; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame into dut_a with m_ready held high; reports cycles to m_valid and the data.
    task automatic send_one_a(input logic [7:0] d, input logic [7:0] f,
                              output int lat, output logic [7:0] got);
        int w;
        tick();
        a_s_valid = 1'b1; a_s_data = d; a_s_frozen = f; a_m_ready = 1'b1;
        @(negedge clk);
        w = 0;
        while (a_s_ready !== 1'b1 && w < 20) begin
            tick();
            @(negedge clk);
            w++;
        end
        lat = -1;
        got = 8'h00;
        if (w < 20) begin
            for (int k = 1; k <= 20; k++) begin
                tick();
                a_s_valid = 1'b0;
                @(negedge clk);
                if (a_m_valid === 1'b1) begin
                    lat = k;
                    got = a_m_data;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_s_valid = 1'b1; b_s_valid = 1'b1; c_s_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_s_ready: got %b want 0", a_s_ready); end
        n_cmp++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_m_valid: got %b want 0", a_m_valid); end
        n_cmp++; if (a_m_data !== 8'h00) begin n_err++; $display("FAIL reset_a_m_data: got %h want 00", a_m_data); end
        n_cmp++; if (a_frame_cnt !== 32'd0) begin n_err++; $display("FAIL reset_a_frame_cnt: got %0d want 0", a_frame_cnt); end
        n_cmp++; if (b_s_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_s_ready: got %b want 0", b_s_ready); end
        n_cmp++; if (b_m_data !== 32'h0) begin n_err++; $display("FAIL reset_b_m_data: got %h want 0", b_m_data); end
        n_cmp++; if (c_frame_cnt !== 4'd0) begin n_err++; $display("FAIL reset_c_frame_cnt: got %0d want 0", c_frame_cnt); end
        tick();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_s_valid = 1'b0; b_s_valid = 1'b0; c_s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_a_s_ready: got %b want 1", a_s_ready); end
        n_cmp++; if (b_s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_b_s_ready: got %b want 1", b_s_ready); end
        n_cmp++; if (c_s_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_c_s_ready: got %b want 1", c_s_ready); end
        n_cmp++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_a_m_valid: got %b want 0", a_m_valid); end
    endtask

    task automatic test_basic();
        int lat;
        logic [7:0] got;
        for (int i = 0; i < 4; i++) begin
            send_one_a(BASIC_IN[i], 8'h00, lat, got);
            n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (got !== BASIC_EXP[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, got, BASIC_EXP[i]); end
            tick();
            @(negedge clk);
            n_cmp++; if (a_frame_cnt !== 32'(i + 1)) begin n_err++; $display("FAIL basic_frame_cnt[%0d]: got %0d want %0d", i, a_frame_cnt, i + 1); end
            n_cmp++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain[%0d]: m_valid got %b want 0", i, a_m_valid); end
        end
    endtask

    task automatic test_frozen();
        int lat;
        logic [7:0] got;
        for (int i = 0; i < 3; i++) begin
            send_one_a(FRZ_IN[i], FRZ_MASK[i], lat, got);
            n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL frozen_latency[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (got !== FRZ_EXP[i]) begin n_err++; $display("FAIL frozen_data[%0d]: got %h want %h", i, got, FRZ_EXP[i]); end
            tick();
            @(negedge clk);
            n_cmp++; if (a_frame_cnt !== 32'(i + 5)) begin n_err++; $display("FAIL frozen_frame_cnt[%0d]: got %0d want %0d", i, a_frame_cnt, i + 5); end
        end
    endtask

    task automatic test_backpressure();
        int sent, recv, cyc;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [7:0] lfsr;
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            bp_din[i] = 8'($urandom);
            bp_fz[i]  = 8'($urandom) & 8'($urandom);
            e = polar_ref({24'h0, bp_din[i] & ~bp_fz[i]}, 8);
            bp_exp[i] = e[7:0];
        end
        tick();
        a_rst = 1'b1; a_s_valid = 1'b0;
        tick();
        a_rst = 1'b0;
        sent = 0; recv = 0; cyc = 0;
        prev_stall = 1'b0; prev_data = 8'h00; lfsr = 8'hA7;
        while (recv < 10 && cyc < 500) begin
            tick();
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            a_m_ready = lfsr[0];
            a_s_valid = (sent < 10) && (lfsr[2] | lfsr[5]);
            if (sent < 10) begin
                a_s_data = bp_din[sent];
                a_s_frozen = bp_fz[sent];
            end
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if (a_m_valid !== 1'b1 || a_m_data !== prev_data) begin
                    n_err++;
                    $display("FAIL bp_stall_hold: got valid=%b data=%h want valid=1 data=%h", a_m_valid, a_m_data, prev_data);
                end
            end
            if (a_m_valid === 1'b1 && a_m_ready === 1'b1) begin
                n_cmp++;
                if (a_m_data !== bp_exp[recv]) begin
                    n_err++;
                    $display("FAIL bp_data[%0d]: got %h want %h", recv, a_m_data, bp_exp[recv]);
                end
                recv++;
            end
            if (a_s_valid === 1'b1 && a_s_ready === 1'b1) sent++;
            prev_stall = (a_m_valid === 1'b1) && (a_m_ready === 1'b0);
            prev_data = a_m_data;
            cyc++;
        end
        n_cmp++; if (recv != 10) begin n_err++; $display("FAIL bp_count: got %0d frames want 10", recv); end
        tick();
        a_s_valid = 1'b0; a_m_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_frame_cnt !== 32'd10) begin n_err++; $display("FAIL bp_frame_cnt: got %0d want 10", a_frame_cnt); end
        n_cmp++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_extra: m_valid got %b want 0", a_m_valid); end
    endtask

    task automatic test_reset_midstream();
        int lat;
        int stale;
        logic [7:0] got;
        send_one_a(8'h80, 8'h00, lat, got);
        for (int i = 0; i < 3; i++) begin
            tick();
            a_s_valid = 1'b1; a_s_data = 8'h01 << i; a_s_frozen = 8'h00; a_m_ready = 1'b1;
            @(negedge clk);
            n_cmp++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL mid_accept[%0d]: s_ready got %b want 1", i, a_s_ready); end
        end
        tick();
        a_s_valid = 1'b0; a_rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_s_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_s_ready: got %b want 0", a_s_ready); end
        tick();
        a_rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid: got %b want 0", a_m_valid); end
        n_cmp++; if (a_m_data !== 8'h00) begin n_err++; $display("FAIL mid_m_data: got %h want 00", a_m_data); end
        n_cmp++; if (a_frame_cnt !== 32'd0) begin n_err++; $display("FAIL mid_frame_cnt: got %0d want 0", a_frame_cnt); end
        n_cmp++; if (a_s_ready !== 1'b1) begin n_err++; $display("FAIL mid_s_ready_after: got %b want 1", a_s_ready); end
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            if (a_m_valid === 1'b1) stale++;
        end
        n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d stale frames want 0", stale); end
    endtask

    task automatic test_throughput_involution();
        int sent, recv, cyc, first_out, gaps, not_ready;
        logic [31:0] e;
        b_m_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            sent = 0; recv = 0; cyc = 0; first_out = -1; gaps = 0; not_ready = 0;
            while (recv < 1000 && cyc < 3000) begin
                tick();
                b_s_valid = (sent < 1000);
                if (sent < 1000) begin
                    if (pass == 0) begin
                        b_s_data = $urandom;
                        b_s_frozen = $urandom & $urandom;
                    end else begin
                        b_s_data = tp_x[sent];
                        b_s_frozen = 32'h0;
                    end
                end
                @(negedge clk);
                if (b_m_valid === 1'b1) begin
                    if (pass == 0) e = polar_ref(tp_u[recv], 32);
                    else e = tp_u[recv];
                    n_cmp++;
                    if (b_m_data !== e) begin
                        n_err++;
                        $display("FAIL tp_data[p%0d][%0d]: got %h want %h", pass, recv, b_m_data, e);
                    end
                    if (pass == 0) tp_x[recv] = b_m_data;
                    if (first_out < 0) first_out = cyc;
                    recv++;
                end else if (recv > 0) begin
                    gaps++;
                end
                if (b_s_valid === 1'b1) begin
                    if (b_s_ready === 1'b1) begin
                        if (pass == 0) tp_u[sent] = b_s_data & ~b_s_frozen;
                        sent++;
                    end else begin
                        not_ready++;
                    end
                end
                cyc++;
            end
            tick();
            b_s_valid = 1'b0;
            n_cmp++; if (recv != 1000) begin n_err++; $display("FAIL tp_count[p%0d]: got %0d want 1000", pass, recv); end
            n_cmp++; if (first_out != 4) begin n_err++; $display("FAIL tp_first[p%0d]: got cycle %0d want 4", pass, first_out); end
            n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL tp_gaps[p%0d]: got %0d want 0", pass, gaps); end
            n_cmp++; if (not_ready != 0) begin n_err++; $display("FAIL tp_stall_in[p%0d]: got %0d want 0", pass, not_ready); end
            for (int k = 0; k < 6; k++) tick();
        end
    endtask

    task automatic test_counter_wrap();
        int sent, recv, cyc;
        logic [31:0] e;
        sent = 0; recv = 0; cyc = 0;
        c_m_ready = 1'b1;
        while (recv < 17 && cyc < 200) begin
            tick();
            c_s_valid = (sent < 17);
            c_s_data = 8'(sent * 37 + 5);
            c_s_frozen = 8'h00;
            @(negedge clk);
            if (c_m_valid === 1'b1) begin
                e = polar_ref({24'h0, wr_u[recv]}, 8);
                n_cmp++;
                if (c_m_data !== e[7:0]) begin
                    n_err++;
                    $display("FAIL wrap_data[%0d]: got %h want %h", recv, c_m_data, e[7:0]);
                end
                recv++;
            end
            if (c_s_valid === 1'b1 && c_s_ready === 1'b1) begin
                wr_u[sent] = c_s_data;
                sent++;
            end
            cyc++;
        end
        tick();
        c_s_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (recv != 17) begin n_err++; $display("FAIL wrap_count: got %0d want 17", recv); end
        n_cmp++; if (c_frame_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_frame_cnt: got %0d want 1", c_frame_cnt); end
    endtask

    initial begin
        a_rst = 1'b1; a_s_valid = 1'b0; a_s_data = '0; a_s_frozen = '0; a_m_ready = 1'b1;
        b_rst = 1'b1; b_s_valid = 1'b0; b_s_data = '0; b_s_frozen = '0; b_m_ready = 1'b1;
        c_rst = 1'b1; c_s_valid = 1'b0; c_s_data = '0; c_s_frozen = '0; c_m_ready = 1'b1;
        test_reset();
        test_basic();
        test_frozen();
        test_backpressure();
        test_reset_midstream();
        test_throughput_involution();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/polar_encoder_pipe.md
# polar_encoder_pipe

Streaming, pipelined polar encoder: accepts one N-bit frame per cycle with a per-frame frozen-bit mask, computes the full log2(N)-stage Arikan transform x = u·F⊗ⁿ, and returns the codeword after a fixed, parameter-determined latency. It generalises the team's combinational polar encoder core with:

- configurable register depth;
- valid/ready backpressure on both sides;
- frozen-bit insertion;
- a frame counter.

It sits between the CRC/info-bit packer and the rate-matching block.

## Interface

Parameters:
- N, 32, codeword length; must be a power of two, 4..1024. Elaboration error otherwise.
- SPR, 1, butterfly stages per register; 1..log2(N). Elaboration error otherwise.
- CNT_W, 32, frame counter width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input frame valid.
- s_ready  out  1  encoder can accept a frame this cycle.
- s_data  in  N  payload bits, bit i = u position i.
- s_frozen  in  N  frozen mask; bit i = 1 forces u[i] = 0.
- m_valid  out  1  codeword valid.
- m_ready  in  1  downstream accepts codeword.
- m_data  out  N  codeword x.
- frame_cnt  out  CNT_W  number of codewords accepted downstream since reset.

## Operation

- Masking: u = s_data & ~s_frozen, captured into register stage 0 on an input handshake (s_valid & s_ready).
- Transform: NSTAGES = log2(N) butterfly stages, s = 0..NSTAGES-1.
  - At stage s, every bit b with bit s of b equal to 0 becomes x[b] ^ x[b + 2^s].
  - All other bits pass through unchanged.
  - All NSTAGES stages are applied; none is skipped.
- Register grouping: stage groups of SPR butterflies, each followed by a register. The number of groups is NG = ceil(NSTAGES/SPR); the last group may be shorter. The last register drives m_data.
- Pipeline control: each register k has a valid bit v[k].
  - adv[k] = v[k] & (k is last ? m_ready : (~v[k+1] | adv[k+1])).
  - Register k loads when its upstream advances. v[k] clears when it advances with nothing arriving.
  - s_ready = ~rst & (~v[0] | adv[0]). This is combinational from m_ready; no skid buffer.
- Bubbles collapse: a stalled output does not prevent upstream empty slots from filling.
- frame_cnt increments on every m_valid & m_ready. Wraps modulo 2^CNT_W with no flag.
- The transform is an involution: encoding an encoder output with an all-zero mask returns the original u.

## Timing

- Latency L = 1 + NG cycles from input handshake to m_valid asserted, absent stalls. Defaults N=32, SPR=1: L = 6.
- Throughput: one frame per cycle while m_ready = 1.
- Stall: while m_valid & ~m_ready, m_data and m_valid hold stable.
- Up to L frames in flight; none are dropped or duplicated.
- Reset (synchronous, any cycle including mid-stream):
  - next cycle all v[k] = 0, m_valid = 0, m_data = 0, frame_cnt = 0;
  - in-flight frames are discarded;
  - s_ready = 0 during any cycle rst = 1.
- Simultaneous input and output handshakes in the same cycle on a full pipeline: both complete and occupancy is unchanged.
- Data registers are don't-care when the matching v = 0, except m_data, which is 0 after reset.

## Structure

- Shared package polar_pkg:
  - function polar_nstages(N) = $clog2(N);
  - function polar_latency(N, SPR) = 1 + ceil(polar_nstages(N)/SPR);
  - N-range and power-of-two check macros.
- Sub-module polar_butterfly_stage:
  - combinational; parameters N and S; one stage;
  - instantiated NSTAGES times via generate.
- Pipeline control is local to polar_encoder_pipe.

## Test plan

All scenarios use N=8, SPR=1 (L=4) unless noted.

1. Basic vectors:
   - s_data=0x80, mask=0x00 -> m_data=0xFF, 4 cycles after accept.
   - 0x02 -> 0x03.
   - 0x01 -> 0x01.
2. Frozen insertion: s_data=0xFF, s_frozen=0x7F -> m_data=0xFF. With s_frozen=0xFF -> m_data=0x00.
3. Backpressure: stream 10 random frames with m_ready toggled in a pseudo-random pattern.
   - Outputs match the golden model in order.
   - m_data is stable during stalls.
   - frame_cnt=10 at the end.
4. Full-throughput and involution, N=32, SPR=2 (L=4): 1000 back-to-back frames.
   - One output per cycle after the first 4 cycles.
   - Feeding each output back with a zero mask returns the original u.
5. Reset mid-stream: assert rst for 1 cycle with 3 frames in flight.
   - Next cycle m_valid=0, m_data=0, frame_cnt=0, and no stale frame emerges.
   - s_ready=1 the cycle after rst deasserts.
6. Counter wrap, CNT_W=4: 17 accepted frames -> frame_cnt=1.
